// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: 4 requesters share one FIFO write port, bursts of up to MAX_BURST words.
// Define ARB_FIXED_PRIO_EN for fixed priority (req0 highest) instead of round-robin.
module fifo_wr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          req,
    input  logic [4*DATA_W-1:0] din,
    input  logic                fifo_full,
    output logic                fifo_we,
    output logic [DATA_W-1:0]   fifo_din,
    output logic [3:0]          ack,
    output logic [3:0]          grant,
    output logic                busy
);
    localparam int NUM_REQ = 4;
    localparam int CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                          state_q, state_d;
    logic [3:0]                      grant_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [1:0]                      owner, sel;
    logic                            push, rel;
    logic [NUM_REQ-1:0][DATA_W-1:0]  din_v;

    assign din_v = din;

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) owner = 2'(i);
    end

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i]) sel = 2'(i);
    end
`else
    logic [1:0] last_q;

    // Scan last+4 (=last) down to last+1 so the nearest successor of last wins.
    always_comb begin
        sel = '0;
        for (int k = NUM_REQ; k >= 1; k--)
            if (req[last_q + 2'(k)]) sel = last_q + 2'(k);
    end

    always_ff @(posedge clk) begin
        if (rst)      last_q <= 2'd3;
        else if (rel) last_q <= owner;
    end
`endif

    assign push     = (state_q == BURST) && req[owner] && !fifo_full && !rst;
    assign rel      = (state_q == BURST) && (!req[owner] || (push && cnt_q == CNT_LAST));
    assign fifo_we  = push;
    assign fifo_din = din_v[owner];
    assign busy     = (state_q == BURST) && !rst;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ack
        assign ack[i] = push && grant[i];
    end

    // Full only stalls: grant and cnt hold until the owner drops req or the burst completes.
    always_comb begin
        state_d = state_q;
        grant_d = grant;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BURST;
                    grant_d = 4'b0001 << sel;
                    cnt_d   = '0;
                end else begin
                    grant_d = '0;
                end
            end
            BURST: begin
                if (rel) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (push) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: MAX_BURST=4 and MAX_BURST=1 instances share stimulus,
// each checked against a word-count/turn-order reference model.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] req;
    logic [4*DW-1:0] din;
    logic full;

    logic          we0, we1, busy0, busy1;
    logic [DW-1:0] fd0, fd1;
    logic [3:0]    ack0, ack1, gr0, gr1;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.DATA_W(DW), .MAX_BURST(4)) u_mb4 (
        .clk(clk), .rst(rst), .req(req), .din(din), .fifo_full(full),
        .fifo_we(we0), .fifo_din(fd0), .ack(ack0), .grant(gr0), .busy(busy0)
    );

    fifo_wr_arbiter #(.DATA_W(DW), .MAX_BURST(1)) u_mb1 (
        .clk(clk), .rst(rst), .req(req), .din(din), .fifo_full(full),
        .fifo_we(we1), .fifo_din(fd1), .ack(ack1), .grant(gr1), .busy(busy1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner index (-1 idle), words still allowed this turn, first index to scan.
    int mb[2]    = '{4, 1};
    int own[2];
    int left[2];
    int start[2];

    logic          e_we[2];
    logic          e_busy[2];
    logic [3:0]    e_ack[2];
    logic [3:0]    e_gr[2];
    logic [DW-1:0] e_din[2];

    function automatic int pick(input logic [3:0] r, input int s);
        for (int k = 0; k < 4; k++)
            if (r[(s + k) % 4]) return (s + k) % 4;
        return -1;
    endfunction

    task automatic model_step(input int m);
        int o;
        int s;
        o         = own[m];
        e_gr[m]   = (o >= 0) ? 4'(1 << o) : 4'b0;
        e_busy[m] = (o >= 0) && !rst;
        e_we[m]   = 1'b0;
        e_ack[m]  = 4'b0;
        e_din[m]  = '0;
`ifdef ARB_FIXED_PRIO_EN
        s = 0;
`else
        s = start[m];
`endif
        if (rst) begin
            own[m]   = -1;
            start[m] = 0;
        end else if (o < 0) begin
            if (req != 4'b0) begin
                own[m]  = pick(req, s);
                left[m] = mb[m];
            end
        end else begin
            if (req[o] && !full) begin
                e_we[m]  = 1'b1;
                e_ack[m] = 4'(1 << o);
                e_din[m] = din[o*DW +: DW];
                left[m]--;
            end
            if (!req[o] || left[m] == 0) begin
                own[m]   = -1;
                start[m] = (o + 1) % 4;
            end
        end
    endtask

    // Called just after the negedge input update: predict, then compare both instances.
    task automatic check_cycle();
        #1;
        model_step(0);
        model_step(1);
        chk("mb4_grant", 32'(gr0), 32'(e_gr[0]));
        chk("mb4_we",    32'(we0), 32'(e_we[0]));
        chk("mb4_ack",   32'(ack0), 32'(e_ack[0]));
        chk("mb4_busy",  32'(busy0), 32'(e_busy[0]));
        if (e_we[0]) chk("mb4_din", 32'(fd0), 32'(e_din[0]));
        chk("mb1_grant", 32'(gr1), 32'(e_gr[1]));
        chk("mb1_we",    32'(we1), 32'(e_we[1]));
        chk("mb1_ack",   32'(ack1), 32'(e_ack[1]));
        chk("mb1_busy",  32'(busy1), 32'(e_busy[1]));
        if (e_we[1]) chk("mb1_din", 32'(fd1), 32'(e_din[1]));
    endtask

    initial begin
        int acks0[4];
        int wes0;
        int wes1;
        logic [3:0] acked;

        rst  = 1'b1;
        req  = '0;
        din  = '0;
        full = 1'b0;
        repeat (2) @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            own[m]   = -1;
            left[m]  = 0;
            start[m] = 0;
        end

        // Reset state, still under reset.
        @(negedge clk);
        check_cycle();

        // All four requesting continuously: rotation 0,1,2,3 with full bursts.
        @(negedge clk);
        rst  = 1'b0;
        req  = 4'b1111;
        din  = {8'hD0, 8'hC0, 8'hB0, 8'hA0};
        for (int i = 0; i < 4; i++) acks0[i] = 0;
        wes0 = 0;
        wes1 = 0;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            check_cycle();
            for (int i = 0; i < 4; i++) acks0[i] += int'(ack0[i]);
            wes0 += int'(we0);
            wes1 += int'(we1);
        end
        for (int i = 0; i < 4; i++) chk("rot_acks", 32'(acks0[i]), 32'd4);
        chk("rot_we_mb4", 32'(wes0), 32'd16);
        chk("rot_we_mb1", 32'(wes1), 32'd10);

        // Mid-burst reset, then req=1001 must grant requester 0 first.
        repeat (3) begin
            @(negedge clk);
            check_cycle();
        end
        @(negedge clk);
        rst = 1'b1;
        check_cycle();
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1001;
        check_cycle();
        @(negedge clk);
        check_cycle();
        chk("rst_then_req0", 32'(gr0), 32'h1);

        // Randomized traffic: requesters hold din until acked, occasionally drop req early.
        acked = e_ack[0];
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (acked[i]) begin
                        if ($urandom_range(3) == 0) req[i] = 1'b0;
                        else din[i*DW +: DW] = 8'($urandom);
                    end else if ($urandom_range(31) == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom_range(2) == 0) begin
                    req[i] = 1'b1;
                    din[i*DW +: DW] = 8'($urandom);
                end
            end
            full = ($urandom_range(3) == 0);
            if (c > 0 && c % 7 == 0 && $urandom_range(15) == 0) full = 1'b1;
            rst = ($urandom_range(127) == 0);
            check_cycle();
            acked = e_ack[0];
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
